pht_access_sched: RTL
=====================

// Module: pht_access_sched
// PURPOSE
//  Sole owner of a single-port, 1-cycle-read PHT RAM of 2-bit predictor counters.
//  Serves fetch-stage prediction lookups and MEM-stage counter updates; the updates are buffered in a FIFO.
//  Each update is a read-modify-write (RMW) of the counter.
//  Also runs the table-initialisation sweep after reset or after a clear request.
//  Sits between the IF/MEM pipeline stages and the PHT RAM macro.
// PARAMETERS
//  IDX_W      6      PHT index width; table holds 2**IDX_W counters
//  FIFO_DEPTH 4      update FIFO entries (power of two, >=2)
//  CTR_INIT   2'b11  counter value written by init sweep (Weakly_taken)
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous reset, active-high
//  clr         in   1      synchronous request: flush FIFO, restart init sweep
//  lkp_valid   in   1      fetch requests prediction for lkp_idx
//  lkp_idx     in   IDX_W  lookup index
//  lkp_ready   out  1      lookup accepted this cycle (valid&ready)
//  rsp_valid   out  1      lookup result valid (1 cycle after accept)
//  rsp_taken   out  1      predicted taken = counter[1]
//  upd_valid   in   1      MEM-stage branch resolved
//  upd_idx     in   IDX_W  index to update
//  upd_taken   in   1      actual branch outcome
//  upd_ready   out  1      FIFO can accept update this cycle
//  init_busy   out  1      init sweep in progress
//  tbl_en      out  1      RAM access enable
//  tbl_we      out  1      RAM write enable
//  tbl_addr    out  IDX_W  RAM address
//  tbl_wdata   out  2      RAM write data
//  tbl_rdata   in   2      RAM read data, valid the cycle after tbl_en&~tbl_we
// BEHAVIOUR
//  Reset: state=INIT, sweep ptr=0, FIFO empty, rsp_valid=0, rsp_taken=0, init_busy=1.
//  Reset: all tbl_* outputs=0 except during INIT writes.
//  Counter encoding: 00 SNT, 01 WNT, 11 WT, 10 ST.
//   taken:     00->01, 01->11, 11->10, 10->10 (saturate).
//   not taken: 10->11, 11->01, 01->00, 00->00 (saturate).
//  FSM states: INIT, IDLE, UPD_RD, UPD_WR.
//   INIT: one write per cycle: addr=ptr, wdata=CTR_INIT; ptr wraps 2**IDX_W-1 -> IDLE.
//   INIT: lkp_ready=0 and upd_ready=0 throughout.
//   IDLE: arbitration priority is
//    (1) FIFO full -> pop head, issue read of head idx, go UPD_RD; lkp_ready=0.
//    (2) else lkp_valid -> lkp_ready=1, issue read of lkp_idx, stay IDLE.
//    (3) else FIFO non-empty -> pop, read, go UPD_RD.
//    (4) else no access.
//   UPD_RD: tbl_rdata holds the old counter; write next-state counter to same idx; go UPD_WR.
//   UPD_WR: one bubble cycle for write completion; go IDLE. lkp_ready=0 in UPD_RD/UPD_WR.
//  rsp_valid=1 exactly one cycle after an accepted lookup; rsp_taken=tbl_rdata[1] that cycle.
//  Lookups accepted back-to-back in IDLE: 1/cycle throughput.
//  Updates: 3 cycles each, strictly serialised. An RMW always completes before the next read.
//  Consecutive updates to the same idx therefore compound (no lost update).
//  upd_ready = ~full & ~init_busy. It uses registered occupancy only (no same-cycle pop credit).
//  Simultaneous push and pop: occupancy unchanged, ordering preserved.
//  upd_valid while upd_ready=0: the update is dropped; the requester must hold it. Never overwrite FIFO.
//  clr (any state, including mid-RMW): next cycle state=INIT, ptr=0, FIFO emptied.
//  clr also drops the pending write and forces rsp_valid=0.
//  clr during INIT restarts the sweep at 0.
//  Async rst mid-operation: immediate return to reset values. The RAM contents are then re-swept.
// TESTING
//  1. Release rst: 64 cycles of INIT writes addr 0..63 data 11, init_busy=1 throughout.
//     Cycle 65: init_busy=0, lkp_ready=1.
//  2. After init, 3 updates idx=5 taken: counter 11->10->10; lookup idx5 -> rsp_taken=1.
//     Then 2 not-taken -> counter 01; lookup idx5 -> rsp_taken=0.
//  3. lkp_valid held high, 4 updates pushed: FIFO fills and the update wins arbitration.
//     lkp_ready=0 during UPD_RD/UPD_WR; upd_ready=0 while full; no update lost.
//  4. Lookups idx 0,1,2 back-to-back: rsp_valid on next 3 cycles with counter[1] of each.
//  5. clr asserted in UPD_RD: no write issued; FIFO empty; full 64-cycle re-sweep.
//     Lookup afterwards returns CTR_INIT[1]=1.
//  6. rst pulsed mid-UPD_WR asynchronously: outputs reset in the same cycle; INIT restarts from 0.

Source files
------------

// File: rtl/pht_access_sched_if.sv
// Bundle of the lookup, update, clear and PHT RAM signals of pht_access_sched.
// The scheduler takes the slave modport; the pipeline/RAM side takes the master modport.
interface pht_access_sched_if #(
  parameter int unsigned IDX_W = 6
);
  logic             clr;
  logic             lkp_valid;
  logic [IDX_W-1:0] lkp_idx;
  logic             lkp_ready;
  logic             rsp_valid;
  logic             rsp_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_ready;
  logic             init_busy;
  logic             tbl_en;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wdata;
  logic [1:0]       tbl_rdata;

  modport slave (
    input  clr, lkp_valid, lkp_idx, upd_valid, upd_idx, upd_taken, tbl_rdata,
    output lkp_ready, rsp_valid, rsp_taken, upd_ready, init_busy,
           tbl_en, tbl_we, tbl_addr, tbl_wdata
  );

  modport master (
    output clr, lkp_valid, lkp_idx, upd_valid, upd_idx, upd_taken, tbl_rdata,
    input  lkp_ready, rsp_valid, rsp_taken, upd_ready, init_busy,
           tbl_en, tbl_we, tbl_addr, tbl_wdata
  );
endinterface

// File: rtl/pht_access_sched.sv
// Arbiter and sole owner of a single-port PHT RAM: serves prediction lookups, runs buffered
// read-modify-write counter updates and the table-initialisation sweep.
module pht_access_sched #(
  parameter int unsigned IDX_W      = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [1:0]  CTR_INIT   = 2'b11
) (
  input logic               clk,
  input logic               rst,
  pht_access_sched_if.slave bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StInit, StIdle, StUpdRd, StUpdWr} state_e;

  state_e           stateQ, stateD;
  logic [IDX_W-1:0] sweepQ, sweepD;
  logic [IDX_W-1:0] updIdxQ, updIdxD;
  logic             updTknQ, updTknD;
  logic             rspValidQ;

  logic [IDX_W-1:0] fifoIdxQ [FIFO_DEPTH];
  logic             fifoTknQ [FIFO_DEPTH];
  logic [PtrW-1:0]  wrPtrQ, rdPtrQ;
  logic [CntW-1:0]  cntQ;

  logic full, empty, push, pop, lkpFire;

  // Counter order SNT 00 < WNT 01 < WT 11 < ST 10, saturating at both ends.
  function automatic logic [1:0] nextCtr(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    unique case (ctr)
      2'b00:   res = taken ? 2'b01 : 2'b00;
      2'b01:   res = taken ? 2'b11 : 2'b00;
      2'b11:   res = taken ? 2'b10 : 2'b01;
      default: res = taken ? 2'b10 : 2'b11;
    endcase
    return res;
  endfunction

  assign full  = (cntQ == FullCnt);
  assign empty = (cntQ == '0);

  assign bus.init_busy = (stateQ == StInit);
  // Registered occupancy only: a pop in the same cycle does not free a slot for a push.
  assign bus.upd_ready = ~full & ~bus.init_busy;
  assign push          = bus.upd_valid & bus.upd_ready;
  assign bus.lkp_ready = lkpFire;
  assign bus.rsp_valid = rspValidQ;
  assign bus.rsp_taken = rspValidQ & bus.tbl_rdata[1];

  always_comb begin
    stateD        = stateQ;
    sweepD        = sweepQ;
    updIdxD       = updIdxQ;
    updTknD       = updTknQ;
    pop           = 1'b0;
    lkpFire       = 1'b0;
    bus.tbl_en    = 1'b0;
    bus.tbl_we    = 1'b0;
    bus.tbl_addr  = '0;
    bus.tbl_wdata = '0;

    unique case (stateQ)
      StInit: begin
        bus.tbl_en    = 1'b1;
        bus.tbl_we    = 1'b1;
        bus.tbl_addr  = sweepQ;
        bus.tbl_wdata = CTR_INIT;
        sweepD        = sweepQ + 1'b1;
        if (sweepQ == '1) stateD = StIdle;
      end
      StIdle: begin
        // A full FIFO beats lookups so updates cannot starve behind a busy fetch stage.
        if (full || (!bus.lkp_valid && !empty)) begin
          pop          = 1'b1;
          bus.tbl_en   = 1'b1;
          bus.tbl_addr = fifoIdxQ[rdPtrQ];
          updIdxD      = fifoIdxQ[rdPtrQ];
          updTknD      = fifoTknQ[rdPtrQ];
          stateD       = StUpdRd;
        end else if (bus.lkp_valid) begin
          lkpFire      = 1'b1;
          bus.tbl_en   = 1'b1;
          bus.tbl_addr = bus.lkp_idx;
        end
      end
      StUpdRd: begin
        bus.tbl_en    = 1'b1;
        bus.tbl_we    = 1'b1;
        bus.tbl_addr  = updIdxQ;
        bus.tbl_wdata = nextCtr(bus.tbl_rdata, updTknQ);
        stateD        = StUpdWr;
      end
      StUpdWr: stateD = StIdle;
      default: stateD = StInit;
    endcase

    // Clear drops any RAM access this cycle, including a pending RMW write.
    if (bus.clr) begin
      stateD        = StInit;
      sweepD        = '0;
      pop           = 1'b0;
      lkpFire       = 1'b0;
      bus.tbl_en    = 1'b0;
      bus.tbl_we    = 1'b0;
      bus.tbl_addr  = '0;
      bus.tbl_wdata = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= StInit;
      sweepQ    <= '0;
      updIdxQ   <= '0;
      updTknQ   <= 1'b0;
      rspValidQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      sweepQ    <= sweepD;
      updIdxQ   <= updIdxD;
      updTknQ   <= updTknD;
      rspValidQ <= lkpFire;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      cntQ   <= '0;
    end else if (bus.clr) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      cntQ   <= '0;
    end else begin
      if (push) wrPtrQ <= wrPtrQ + 1'b1;
      if (pop)  rdPtrQ <= rdPtrQ + 1'b1;
      cntQ <= cntQ + CntW'(push) - CntW'(pop);
    end
  end

  // Payload storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoIdxQ[wrPtrQ] <= bus.upd_idx;
      fifoTknQ[wrPtrQ] <= bus.upd_taken;
    end
  end

endmodule
